// File: rtl/ex_branch_resolve.sv
// ----------------------------------------------------------------------------
// ex_branch_resolve
//
// Execute-stage branch resolution and EX/MEM pipeline register.
//   - Resolves conditional branches and jumps against the prediction carried
//     with the instruction; raises RedirectE/FlushDE with RedirectPCE on a
//     mispredict (combinational, same cycle as the instruction in EX).
//   - Holds a 2-bit saturating BHT indexed by PC[BHT_IDX_W+1:2]; fetch reads
//     it through PCF/PredTakenF, execute updates it for fired branches.
//   - Registers the EX values into the M stage unless StallM is high.
//   - Counts resolved branches/jumps and mispredicts (saturating).
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   PCF / PredTakenF           fetch-side BHT lookup
//   ValidE..RegWriteE, StallM  EX-stage instruction and M-stage back-pressure
//   RedirectE/RedirectPCE/FlushDE  mispredict redirect to fetch and hazard unit
//   ValidM..RdM                registered EX/MEM copies
//   BrCount, MispCount         performance counters
//
// Configuration macro: BRANCH_PRED_EN
//   defined   -> BHT present, PredTakenE honoured
//   undefined -> no BHT, PredTakenF = 0, PredTakenE treated as 0
// ----------------------------------------------------------------------------
module ex_branch_resolve #(
  parameter int BHT_IDX_W = 6,
  parameter int CNT_W     = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [31:0]       PCF,
  output logic              PredTakenF,
  input  logic              ValidE,
  input  logic              BranchE,
  input  logic              JumpE,
  input  logic              ZeroE,
  input  logic              PredTakenE,
  input  logic [31:0]       PCE,
  input  logic [31:0]       PCTargetE,
  input  logic [31:0]       PCPlus4E,
  input  logic [31:0]       ALUResultE,
  input  logic [31:0]       WriteDataE,
  input  logic [4:0]        RdE,
  input  logic              RegWriteE,
  input  logic              StallM,
  output logic              RedirectE,
  output logic [31:0]       RedirectPCE,
  output logic              FlushDE,
  output logic              ValidM,
  output logic              RegWriteM,
  output logic [31:0]       ALUResultM,
  output logic [31:0]       WriteDataM,
  output logic [31:0]       PCPlus4M,
  output logic [4:0]        RdM,
  output logic [CNT_W-1:0]  BrCount,
  output logic [CNT_W-1:0]  MispCount
);

  localparam int BHT_N = 2**BHT_IDX_W;

  function automatic logic [1:0] sat_inc2(input logic [1:0] v);
    if (v == 2'b11) return v;
    else            return v + 2'b01;
  endfunction

  function automatic logic [1:0] sat_dec2(input logic [1:0] v);
    if (v == 2'b00) return v;
    else            return v - 2'b01;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc_cnt(input logic [CNT_W-1:0] v);
    if (v == {CNT_W{1'b1}}) return v;
    else                    return v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  logic fire_s, pred_e_s, taken_s, ctrl_s, misp_s;

  assign fire_s  = ValidE & ~StallM;
`ifdef BRANCH_PRED_EN
  assign pred_e_s = PredTakenE;
`else
  // Static not-taken: a carried prediction bit is meaningless here.
  assign pred_e_s = 1'b0;
`endif
  assign taken_s = JumpE | (BranchE & ZeroE);
  assign ctrl_s  = BranchE | JumpE;
  assign misp_s  = ctrl_s & (taken_s != pred_e_s);

  assign RedirectE   = fire_s & misp_s;
  assign RedirectPCE = taken_s ? PCTargetE : PCPlus4E;
  assign FlushDE     = RedirectE;

`ifdef BRANCH_PRED_EN
  logic [1:0]           bht_q [BHT_N];
  logic [1:0]           bht_d [BHT_N];
  logic [BHT_IDX_W-1:0] idx_f_s, idx_e_s;
  logic                 unused_pc_s;

  assign idx_f_s     = PCF[BHT_IDX_W+1:2];
  assign idx_e_s     = PCE[BHT_IDX_W+1:2];
  assign unused_pc_s = ^{PCF[31:BHT_IDX_W+2], PCF[1:0], PCE[31:BHT_IDX_W+2], PCE[1:0]};

  // Read the registered table only: same-cycle updates are not bypassed.
  assign PredTakenF = bht_q[idx_f_s][1];

  // Next BHT state: train the EX entry on a fired conditional branch.
  always_comb begin
    bht_d = bht_q;
    if (fire_s && BranchE) begin
      if (taken_s) bht_d[idx_e_s] = sat_inc2(bht_q[idx_e_s]);
      else         bht_d[idx_e_s] = sat_dec2(bht_q[idx_e_s]);
    end else begin
      bht_d = bht_q;
    end
  end

  // BHT storage, reset to weakly not-taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BHT_N; i++) bht_q[i] <= 2'b01;
    end else begin
      bht_q <= bht_d;
    end
  end
`else
  logic unused_pred_s;
  assign unused_pred_s = ^{PCF, PCE, PredTakenE};
  assign PredTakenF    = 1'b0;
`endif

  logic              valid_m_q, valid_m_d, regwrite_m_q, regwrite_m_d;
  logic [31:0]       alu_m_q, alu_m_d, wdata_m_q, wdata_m_d, pc4_m_q, pc4_m_d;
  logic [4:0]        rd_m_q, rd_m_d;
  logic [CNT_W-1:0]  br_cnt_q, br_cnt_d, misp_cnt_q, misp_cnt_d;

  // EX/MEM capture and counter next-state.
  always_comb begin
    valid_m_d    = valid_m_q;
    regwrite_m_d = regwrite_m_q;
    alu_m_d      = alu_m_q;
    wdata_m_d    = wdata_m_q;
    pc4_m_d      = pc4_m_q;
    rd_m_d       = rd_m_q;
    br_cnt_d     = br_cnt_q;
    misp_cnt_d   = misp_cnt_q;
    if (!StallM) begin
      valid_m_d    = ValidE;
      regwrite_m_d = ValidE & RegWriteE;
      alu_m_d      = ALUResultE;
      wdata_m_d    = WriteDataE;
      pc4_m_d      = PCPlus4E;
      rd_m_d       = RdE;
    end else begin
      valid_m_d    = valid_m_q;
    end
    if (fire_s && ctrl_s) begin
      br_cnt_d = sat_inc_cnt(br_cnt_q);
      if (misp_s) misp_cnt_d = sat_inc_cnt(misp_cnt_q);
      else        misp_cnt_d = misp_cnt_q;
    end else begin
      br_cnt_d = br_cnt_q;
    end
  end

  // EX/MEM register and counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_m_q    <= 1'b0;
      regwrite_m_q <= 1'b0;
      alu_m_q      <= 32'h0;
      wdata_m_q    <= 32'h0;
      pc4_m_q      <= 32'h0;
      rd_m_q       <= 5'h0;
      br_cnt_q     <= {CNT_W{1'b0}};
      misp_cnt_q   <= {CNT_W{1'b0}};
    end else begin
      valid_m_q    <= valid_m_d;
      regwrite_m_q <= regwrite_m_d;
      alu_m_q      <= alu_m_d;
      wdata_m_q    <= wdata_m_d;
      pc4_m_q      <= pc4_m_d;
      rd_m_q       <= rd_m_d;
      br_cnt_q     <= br_cnt_d;
      misp_cnt_q   <= misp_cnt_d;
    end
  end

  assign ValidM     = valid_m_q;
  assign RegWriteM  = regwrite_m_q;
  assign ALUResultM = alu_m_q;
  assign WriteDataM = wdata_m_q;
  assign PCPlus4M   = pc4_m_q;
  assign RdM        = rd_m_q;
  assign BrCount    = br_cnt_q;
  assign MispCount  = misp_cnt_q;

endmodule

// File: tb/tb_ex_branch_resolve.sv
// Bench for ex_branch_resolve: directed scenarios followed by random traffic,
// all checked against a table-and-counter reference model.
module tb_ex_branch_resolve;

`ifdef BRANCH_PRED_EN
  localparam bit PRED = 1'b1;
`else
  localparam bit PRED = 1'b0;
`endif

  logic        clk = 1'b0, rst_n = 1'b0;
  logic [31:0] PCF = 32'h0, PCE = 32'h0, PCTargetE = 32'h0, PCPlus4E = 32'h0;
  logic [31:0] ALUResultE = 32'h0, WriteDataE = 32'h0;
  logic [4:0]  RdE = 5'h0;
  logic        ValidE = 1'b0, BranchE = 1'b0, JumpE = 1'b0, ZeroE = 1'b0;
  logic        PredTakenE = 1'b0, RegWriteE = 1'b0, StallM = 1'b0;
  logic        PredTakenF, RedirectE, FlushDE, ValidM, RegWriteM;
  logic [31:0] RedirectPCE, ALUResultM, WriteDataM, PCPlus4M, BrCount, MispCount;
  logic [4:0]  RdM;

  ex_branch_resolve #(.BHT_IDX_W(6), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .PCF(PCF), .PredTakenF(PredTakenF),
    .ValidE(ValidE), .BranchE(BranchE), .JumpE(JumpE), .ZeroE(ZeroE),
    .PredTakenE(PredTakenE), .PCE(PCE), .PCTargetE(PCTargetE), .PCPlus4E(PCPlus4E),
    .ALUResultE(ALUResultE), .WriteDataE(WriteDataE), .RdE(RdE), .RegWriteE(RegWriteE),
    .StallM(StallM), .RedirectE(RedirectE), .RedirectPCE(RedirectPCE), .FlushDE(FlushDE),
    .ValidM(ValidM), .RegWriteM(RegWriteM), .ALUResultM(ALUResultM),
    .WriteDataM(WriteDataM), .PCPlus4M(PCPlus4M), .RdM(RdM),
    .BrCount(BrCount), .MispCount(MispCount)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;

  // Reference model state
  int          bht_m [64];
  bit          m_valid, m_rw;
  logic [31:0] m_alu, m_wd, m_p4;
  logic [4:0]  m_rd;
  int unsigned br_m, mis_m;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 64; i++) bht_m[i] = 1;
    m_valid = 0; m_rw = 0; m_alu = 0; m_wd = 0; m_p4 = 0; m_rd = 0;
    br_m = 0; mis_m = 0;
  endtask

  function automatic bit pred_of(input logic [31:0] pc);
    return PRED && (bht_m[(pc >> 2) % 64] >= 2);
  endfunction

  // One clock of traffic with the inputs currently driven.
  task automatic cycle();
    bit fire, pe, tk, mp;
    int ie;
    #2;
    fire = ValidE && !StallM;
    pe   = PRED && PredTakenE;
    tk   = JumpE || (BranchE && ZeroE);
    mp   = (BranchE || JumpE) && (tk != pe);
    check("redirect",    {31'b0, RedirectE},  {31'b0, fire && mp});
    check("flush",       {31'b0, FlushDE},    {31'b0, fire && mp});
    check("redirect_pc", RedirectPCE,         tk ? PCTargetE : PCPlus4E);
    check("predF_pre",   {31'b0, PredTakenF}, {31'b0, pred_of(PCF)});
    if (!StallM) begin
      m_valid = ValidE; m_rw = ValidE && RegWriteE;
      m_alu = ALUResultE; m_wd = WriteDataE; m_p4 = PCPlus4E; m_rd = RdE;
    end
    if (fire && BranchE) begin
      ie = (PCE >> 2) % 64;
      if (tk) bht_m[ie] = (bht_m[ie] == 3) ? 3 : bht_m[ie] + 1;
      else    bht_m[ie] = (bht_m[ie] == 0) ? 0 : bht_m[ie] - 1;
    end
    if (fire && (BranchE || JumpE)) begin
      br_m++;
      if (mp) mis_m++;
    end
    @(posedge clk); #1;
    check("validM",    {31'b0, ValidM},    {31'b0, m_valid});
    check("regwriteM", {31'b0, RegWriteM}, {31'b0, m_rw});
    check("aluM",      ALUResultM, m_alu);
    check("wdataM",    WriteDataM, m_wd);
    check("pc4M",      PCPlus4M,   m_p4);
    check("rdM",       {27'b0, RdM}, {27'b0, m_rd});
    check("brcount",   BrCount,    br_m);
    check("mispcount", MispCount,  mis_m);
    check("predF_post", {31'b0, PredTakenF}, {31'b0, pred_of(PCF)});
  endtask

  task automatic issue(input bit br, input bit jp, input bit z, input bit pte,
                       input logic [31:0] pc, input logic [31:0] tgt);
    ValidE = 1; StallM = 0; BranchE = br; JumpE = jp; ZeroE = z; PredTakenE = pte;
    PCE = pc; PCTargetE = tgt; PCPlus4E = pc + 32'd4;
    ALUResultE = $urandom; WriteDataE = $urandom; RdE = 5'($urandom); RegWriteE = 1'($urandom);
    cycle();
  endtask

  task automatic rand_traffic(input int n);
    for (int i = 0; i < n; i++) begin
      ValidE = ($urandom_range(0, 3) != 0); StallM = ($urandom_range(0, 3) == 0);
      BranchE = 1'($urandom); JumpE = ($urandom_range(0, 5) == 0); ZeroE = 1'($urandom);
      PredTakenE = 1'($urandom);
      PCE = {24'h0, 4'($urandom), 2'b00} + 32'h100 * $urandom_range(0, 1);
      PCF = {24'h0, 4'($urandom), 2'b00};
      PCTargetE = $urandom; PCPlus4E = PCE + 32'd4;
      ALUResultE = $urandom; WriteDataE = $urandom; RdE = 5'($urandom); RegWriteE = 1'($urandom);
      cycle();
    end
  endtask

  logic [31:0] hold_alu;

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    rand_traffic(30);

    // Reset asserted mid-traffic clears state at once.
    ValidE = 1; RegWriteE = 1; BranchE = 1; ZeroE = 1;
    #2 rst_n = 0;
    #1;
    model_reset();
    check("rst_validM",    {31'b0, ValidM},    32'd0);
    check("rst_regwriteM", {31'b0, RegWriteM}, 32'd0);
    check("rst_brcount",   BrCount,   32'd0);
    check("rst_mispcount", MispCount, 32'd0);
    for (int i = 0; i < 8; i++) begin
      PCF = $urandom; #1;
      check("rst_predF", {31'b0, PredTakenF}, 32'd0);
    end
    @(posedge clk); #1 rst_n = 1;
    PCF = 32'h40;

    // Training at 0x40.
    issue(1, 0, 1, 0, 32'h40, 32'h1000);
    issue(1, 0, 1, 0, 32'h40, 32'h1000);
    check("train_predF", {31'b0, PredTakenF}, {31'b0, PRED});
    issue(1, 0, 1, 1, 32'h40, 32'h1000);
    check("train_br", BrCount, 32'd3);

    // Saturation at 0x80.
    PCF = 32'h80;
    repeat (5) issue(1, 0, 1, 0, 32'h80, 32'h2000);
    issue(1, 0, 0, 1, 32'h80, 32'h2000);
    check("sat_predF_hi", {31'b0, PredTakenF}, {31'b0, PRED});
    repeat (3) issue(1, 0, 0, 1, 32'h80, 32'h2000);
    check("sat_predF_lo", {31'b0, PredTakenF}, 32'd0);

    // Jump: always redirects when predicted not-taken, BHT untouched.
    PCF = 32'hC0;
    issue(0, 1, 0, 0, 32'hC0, 32'h200);

    // Stall with a mispredicted branch in EX.
    PCF = 32'h40;
    hold_alu = ALUResultM;
    ValidE = 1; StallM = 1; BranchE = 1; JumpE = 0; ZeroE = 0; PredTakenE = 1;
    PCE = 32'h40; PCTargetE = 32'h3000; PCPlus4E = 32'h44; ALUResultE = ~hold_alu;
    repeat (3) cycle();
    check("stall_hold_alu", ALUResultM, hold_alu);
    StallM = 0;
    cycle();

    // Same-cycle read/update of idx 5 through two aliasing PCs.
    PCF = 32'h14;
    issue(1, 0, 1, 0, 32'h114, 32'h4000);
    issue(1, 0, 1, 0, 32'h114, 32'h4000);

    rand_traffic(400);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ex_branch_resolve.md
# ex_branch_resolve

Execute-stage consumer of the ALU's branch condition and result. It resolves conditional branches and jumps against the fetch-time prediction and issues a redirect and flush on a mispredict. It maintains a 2-bit saturating branch history table (BHT) that fetch reads and execute updates, and it holds the EX/MEM pipeline register for the ALU result. It sits between the ALU and the memory stage and drives the PC-select and hazard-flush logic.

## Interface
Parameters:
- BHT_IDX_W, 6, BHT index width; the table has 2**BHT_IDX_W entries and is indexed by PC[BHT_IDX_W+1:2]
- CNT_W, 32, width of each performance counter

Ports:
- clk  in  1  pipeline clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- PCF  in  32  fetch PC used for the BHT lookup
- PredTakenF  out  1  prediction for PCF: BHT[idx(PCF)][1]
- ValidE  in  1  an instruction is present in EX
- BranchE  in  1  the instruction in EX is a conditional branch
- JumpE  in  1  the instruction in EX is jal/jalr
- ZeroE  in  1  branch condition from the ALU (1 = condition true)
- PredTakenE  in  1  prediction carried down the pipe with the instruction
- PCE  in  32  PC of the instruction in EX
- PCTargetE  in  32  branch/jump target
- PCPlus4E  in  32  fall-through PC
- ALUResultE  in  32  ALU result
- WriteDataE  in  32  store data
- RdE  in  5  destination register
- RegWriteE  in  1  register write enable
- StallM  in  1  memory stage not accepting
- RedirectE  out  1  mispredict redirect, combinational
- RedirectPCE  out  32  PC to fetch when RedirectE=1
- FlushDE  out  1  flush the IF/ID and ID/EX registers (equals RedirectE)
- ValidM, RegWriteM  out  1 each  registered copies
- ALUResultM, WriteDataM, PCPlus4M  out  32 each  registered copies
- RdM  out  5  registered copy
- BrCount, MispCount  out  CNT_W each  performance counters

## Operation
- Fire condition: fireE = ValidE & !StallM. Nothing commits or updates unless fireE is 1.
- Actual outcome: takenE = JumpE | (BranchE & ZeroE).
- Mispredict: mispE = (BranchE | JumpE) & (takenE != PredTakenE).
- Redirect: RedirectE = fireE & mispE. RedirectPCE = takenE ? PCTargetE : PCPlus4E.
- Non-branch instructions never redirect, regardless of PredTakenE.
- BHT update: when fireE & BranchE, the entry at idx(PCE) is incremented (saturating at 3) if takenE and decremented (saturating at 0) otherwise. Jumps do not update the BHT.
- BHT lookup: combinational read of the registered state. If the same entry is read and updated in the same cycle, the read returns the pre-update value (no bypass).
- EX/MEM register:
  - StallM=1: all M outputs hold.
  - StallM=0: capture the EX values, and ValidM <= ValidE.
  - When ValidE=0, RegWriteM is forced to 0.
- Counters: on fireE & (BranchE|JumpE), BrCount increments. If mispE is also 1, MispCount increments. Both counters saturate at all-ones.

## Timing
- Reset values (asynchronous, on rst_n low):
  - Every BHT entry = 2'b01 (weakly not-taken).
  - All M outputs = 0, ValidM = 0.
  - BrCount = 0, MispCount = 0.
- RedirectE, RedirectPCE and FlushDE are valid in the same cycle as the instruction in EX. Fetch uses them on the next rising edge.
- M-stage latency is 1 cycle from EX when StallM=0.
- BHT update is visible to PredTakenF from the cycle after the update edge.
- Stall while a mispredicted branch sits in EX: no redirect, no BHT/counter update. The branch resolves in the first cycle StallM falls.
- Reset asserted mid-operation clears all state immediately. After reset release, the first fetch prediction is not-taken.

## Configuration
- BRANCH_PRED_EN defined: BHT present and behaves as described.
- BRANCH_PRED_EN undefined:
  - No BHT storage; PredTakenF is tied to 0 (static not-taken).
  - PredTakenE is ignored and treated as 0, so every taken branch or jump redirects.
  - Counters remain.

## Test plan
- Reset: assert rst_n=0 mid-traffic -> ValidM=0, RegWriteM=0, BrCount=0, MispCount=0, PredTakenF=0 for any PCF.
- Training: branch at PCE=0x40, taken, PredTakenE=0, issued twice -> first issue gives RedirectE=1, RedirectPCE=PCTargetE; PredTakenF for PCF=0x40 then reads 1. Third issue with PredTakenE=1 -> no redirect. Counters read BrCount=3, MispCount=2.
- Saturation: five taken updates then one not-taken at PC 0x80 -> entry=2, PredTakenF=1. Three more not-taken -> entry=0, PredTakenF=0.
- Jump: JumpE=1, PredTakenE=0, PCTargetE=0x200 -> RedirectE=1, RedirectPCE=0x200, FlushDE=1, BHT entry unchanged.
- Stall: mispredicted branch in EX with StallM=1 for 3 cycles -> RedirectE=0 and M outputs hold through the stall. Cycle 4 with StallM=0 -> RedirectE=1 and a single counter increment.
- Aliasing/same-cycle: PCF and PCE both map to idx 5 with a taken update -> PredTakenF shows the old value that cycle and the new value the next cycle.
- With BRANCH_PRED_EN undefined: any taken branch -> RedirectE=1 and PredTakenF=0 constantly.
